// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default address width and Gray/binary conversion.
// Functions work on any width up to FN_W; zero-extend the argument and truncate the result.
package fifo_pkg;

  localparam int ADD_SIZE_DEF = 8;
  localparam int FN_W         = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unaffected.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer moves to the winner on advance_i.
// No grant while enable_i is low; requesters hold their request until granted.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       enable_i,
  input  logic                       advance_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] rr_last_q;
  logic [IW-1:0] cand;
  logic          found;

  // Search upward starting one past the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(rr_last_q) + k) % NUM_REQ);
      if (enable_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_q <= IW'(NUM_REQ - 1);
    end else if (advance_i) begin
      rr_last_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl_arb.sv
// Async-FIFO write controller: round-robin write-port sharing, binary/Gray write pointer, registered full.
// Write commits at the edge ending the grant cycle; optional almost_full under `ALMOST_FULL_EN.
module fifo_wr_ctrl_arb
  import fifo_pkg::*;
#(
  parameter int ADD_SIZE = ADD_SIZE_DEF,
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8
`ifdef ALMOST_FULL_EN
  ,
  parameter int unsigned AF_THRESH = 2**ADD_SIZE - 4
`endif
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [ADD_SIZE:0]         rd_ptr_sync,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_en,
  output logic [ADD_SIZE-1:0]       wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [ADD_SIZE:0]         wr_ptr,
  output logic                      full
`ifdef ALMOST_FULL_EN
  ,
  output logic                      almost_full
`endif
);

  localparam int PW = ADD_SIZE + 1;
  localparam int IW = $clog2(NUM_REQ);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          full_q, full_d;
  logic          arb_en;
  logic [IW-1:0] grant_idx;

  // Grants are blocked while full or while reset is held.
  assign arb_en = ~full_q & ~wr_rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i       (wr_clk),
    .rst_i       (wr_rst),
    .req_i       (req),
    .enable_i    (arb_en),
    .advance_i   (wr_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign wr_en   = |grant;
  assign wr_addr = wbin_q[ADD_SIZE-1:0];

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_en && grant_idx == IW'(i)) begin
        wr_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  always_comb begin
    wbin_d   = wbin_q + PW'(wr_en);
    wr_ptr_d = PW'(bin2gray(FN_W'(wbin_d)));
    full_d   = (wr_ptr_d == {~rd_ptr_sync[ADD_SIZE -: 2], rd_ptr_sync[ADD_SIZE-2:0]});
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin_q   <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign full   = full_q;

`ifdef ALMOST_FULL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] occ;
  logic          af_q, af_d;

  // Advisory occupancy flag; does not gate grants.
  always_comb begin
    rbin = PW'(gray2bin(FN_W'(rd_ptr_sync)));
    occ  = wbin_d - rbin;
    af_d = FN_W'(occ) >= AF_THRESH;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl_arb.sv
// Directed bench for fifo_wr_ctrl_arb with ADD_SIZE=3, NUM_REQ=4, DATA_W=8.
module tb_fifo_wr_ctrl_arb;

  logic        wr_clk = 1'b0;
  logic        wr_rst = 1'b1;
  logic [3:0]  req = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  rd_ptr_sync = 4'h0;
  logic [3:0]  grant;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  wr_ptr;
  logic        full;
`ifdef ALMOST_FULL_EN
  logic        almost_full;
`endif

  int checks   = 0;
  int failures = 0;

  fifo_wr_ctrl_arb #(
    .ADD_SIZE (3),
    .NUM_REQ  (4),
    .DATA_W   (8)
`ifdef ALMOST_FULL_EN
    ,
    .AF_THRESH(6)
`endif
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .req         (req),
    .req_data    (req_data),
    .rd_ptr_sync (rd_ptr_sync),
    .grant       (grant),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ptr      (wr_ptr),
    .full        (full)
`ifdef ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rd;
    logic [3:0] g;
    logic       we;
    logic [2:0] addr;
    logic [7:0] dat;
    logic [3:0] ptr;
    logic       full;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] sl[4];

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic we, input logic [2:0] addr,
                         input logic [7:0] dat, input logic [3:0] ptr, input logic fl);
    chk({tag, ".grant"},   32'(grant),   32'(g));
    chk({tag, ".wr_en"},   32'(wr_en),   32'(we));
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(addr));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(dat));
    chk({tag, ".wr_ptr"},  32'(wr_ptr),  32'(ptr));
    chk({tag, ".full"},    32'(full),    32'(fl));
  endtask

  initial begin
    sl[0] = 8'hA0; sl[1] = 8'hB1; sl[2] = 8'hC2; sl[3] = 8'hD3;
    req_data = {sl[3], sl[2], sl[1], sl[0]};

    // Round-robin fill of all 8 entries, then full release by one read.
    for (int k = 0; k < 8; k++) begin
      tbl[k] = '{4'hF, 4'h0, 4'(1 << (k % 4)), 1'b1, 3'(k), sl[k % 4], gray4(k), 1'b0};
    end
    tbl[8]  = '{4'hF, 4'h0,     4'h0, 1'b0, 3'd0, 8'h00, 4'b1100, 1'b1};
    tbl[9]  = '{4'hF, gray4(1), 4'h0, 1'b0, 3'd0, 8'h00, 4'b1100, 1'b1};
    tbl[10] = '{4'hF, gray4(1), 4'h1, 1'b1, 3'd0, 8'hA0, 4'b1100, 1'b0};
    tbl[11] = '{4'hF, gray4(1), 4'h0, 1'b0, 3'd1, 8'h00, 4'b1101, 1'b1};

    // Reset held with all requests asserted.
    req = 4'hF;
    repeat (2) @(negedge wr_clk);
    #1;
    chk_all("reset", 4'h0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      @(negedge wr_clk);
      wr_rst      = 1'b0;
      req         = tbl[i].req;
      rd_ptr_sync = tbl[i].rd;
      #1;
      chk_all($sformatf("rr%0d", i), tbl[i].g, tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].ptr, tbl[i].full);
    end

    // Mid-operation reset clears pointers and full immediately.
    @(negedge wr_clk);
    wr_rst = 1'b1;
    #1;
    chk_all("midrst", 4'h0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b0);

    // 16 writes with the read pointer trailing: wraps without full.
    for (int n = 0; n < 16; n++) begin
      @(negedge wr_clk);
      wr_rst      = 1'b0;
      req         = 4'hF;
      rd_ptr_sync = gray4(n >= 2 ? n - 2 : 0);
      #1;
      chk_all($sformatf("wrap%0d", n), 4'(1 << (n % 4)), 1'b1, 3'(n % 8), sl[n % 4], gray4(n), 1'b0);
    end
    @(negedge wr_clk);
    req = 4'h0;
    #1;
    chk_all("wrap_end", 4'h0, 1'b0, 3'd0, 8'h00, 4'b0000, 1'b0);

    // Sparse requesters 1 and 3 alternate.
    @(negedge wr_clk);
    wr_rst = 1'b1;
    rd_ptr_sync = 4'h0;
    req_data = {8'hB3, 8'h5C, 8'hA1, 8'h00};
    @(negedge wr_clk);
    wr_rst = 1'b0;
    req    = 4'b1010;
    for (int m = 0; m < 5; m++) begin
      if (m > 0) @(negedge wr_clk);
      #1;
      chk_all($sformatf("sparse%0d", m), (m % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1, 3'(m),
              (m % 2 == 0) ? 8'hA1 : 8'hB3, gray4(m), 1'b0);
    end

    // Idle cycles must not move the priority pointer (last winner was requester 1).
    for (int m = 0; m < 2; m++) begin
      @(negedge wr_clk);
      req = 4'h0;
      #1;
      chk_all($sformatf("idle%0d", m), 4'h0, 1'b0, 3'd5, 8'h00, gray4(5), 1'b0);
    end
    @(negedge wr_clk);
    req = 4'b0110;
    #1;
    chk_all("resume", 4'b0100, 1'b1, 3'd5, 8'h5C, gray4(5), 1'b0);

`ifdef ALMOST_FULL_EN
    @(negedge wr_clk);
    wr_rst = 1'b1;
    req    = 4'h0;
    @(negedge wr_clk);
    #1;
    chk("af_reset", 32'(almost_full), 32'd0);
    for (int w = 0; w < 6; w++) begin
      if (w > 0) @(negedge wr_clk);
      wr_rst      = 1'b0;
      req         = 4'b0001;
      rd_ptr_sync = 4'h0;
      #1;
      if (w == 5) chk("af_after5", 32'(almost_full), 32'd0);
    end
    @(negedge wr_clk);
    req = 4'h0;
    #1;
    chk("af_after6", 32'(almost_full), 32'd1);
    rd_ptr_sync = gray4(2);
    @(negedge wr_clk);
    #1;
    chk("af_read2", 32'(almost_full), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl_arb.md
Name: fifo_wr_ctrl_arb

Overview:
Write-side controller for the async FIFO, running in the wr_clk domain. It shares the single FIFO write port between NUM_REQ requesters using round-robin arbitration. It maintains the binary write address and the Gray write pointer that is handed to the read domain. It generates a registered full flag by comparing against the read pointer that has already been synchronised into wr_clk.

Parameters:
- ADD_SIZE, 8, FIFO address width; depth = 2**ADD_SIZE; must be >= 2.
- NUM_REQ, 4, number of write requesters; must be >= 2.
- DATA_W, 8, data width per requester.

Ports:
- wr_clk  in  1  write clock.
- wr_rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester write request; level, held until granted.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies slice [i*DATA_W +: DATA_W].
- rd_ptr_sync  in  ADD_SIZE+1  Gray read pointer, already synchronised to wr_clk.
- grant  out  NUM_REQ  one-hot, combinational; the granted requester's data is written this cycle.
- wr_en  out  1  FIFO memory write enable; equals OR of grant.
- wr_addr  out  ADD_SIZE  memory write address; low bits of the binary pointer.
- wr_data  out  DATA_W  data of the granted requester; zero when no grant.
- wr_ptr  out  ADD_SIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
- full  out  1  registered FIFO full flag.

Behaviour:
- Reset (async on wr_rst rising, held while high):
  - wbin = 0, wr_ptr = 0, full = 0.
  - Round-robin priority pointer rr_last = NUM_REQ-1, so requester 0 has highest priority first.
  - grant/wr_en/wr_data evaluate to 0 while wr_rst = 1.
- Arbitration (combinational):
  - If full = 1 or req = 0: grant = 0.
  - Otherwise grant the first asserted req searching upward from rr_last+1, wrapping modulo NUM_REQ.
  - At most one write per cycle.
- On a wr_clk edge with wr_en = 1:
  - Memory writes wr_data at wr_addr.
  - wbin increments by 1; ADD_SIZE+1 bits, wraps 2**(ADD_SIZE+1)-1 -> 0.
  - rr_last takes the index of the granted requester.
- rr_last is unchanged on idle cycles. Fairness: a continuously requesting requester waits at most NUM_REQ-1 writes.
- Pointer arithmetic:
  - wbin_next = wbin + wr_en.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wr_ptr <= wgray_next each cycle.
- Full:
  - full <= (wgray_next == {~rd_ptr_sync[ADD_SIZE:ADD_SIZE-1], rd_ptr_sync[ADD_SIZE-2:0]}).
  - Asserts in the same edge as the write that fills the last entry, so there is zero-cycle overflow exposure.
  - Deasserts one cycle after rd_ptr_sync advances; this is pessimistic and safe.
- Write latency: data is committed at the edge ending the grant cycle. The pointer is visible on wr_ptr at that same edge.
- Requester contract: keep req and data stable until grant; drop or advance req in the cycle after grant.
- Simultaneous full-clear and requests: grant resumes in the first cycle with full = 0; no request is lost.
- Reset mid-operation: pointers return to 0 immediately. The read side must be reset coherently; this block does not handshake reset.

Optional Feature:
Macro ALMOST_FULL_EN.
- Defined:
  - Adds parameter AF_THRESH (default 2**ADD_SIZE-4) and output almost_full (1 bit, reset 0).
  - rbin = Gray-to-binary of rd_ptr_sync.
  - almost_full <= ((wbin_next - rbin) mod 2**(ADD_SIZE+1)) >= AF_THRESH.
  - Advisory only; it does not gate grants.
- Undefined: no port, no logic, no Gray-to-binary converter.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised on width.
  - Default ADD_SIZE constant shared with the synchroniser and read-side blocks.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req, enable (= ~full), advance (= wr_en), clock, reset.
  - Holds rr_last internally; outputs one-hot grant and granted index.

Test Plan (ADD_SIZE=3 so depth = 8, NUM_REQ=4, DATA_W=8):
- Reset: assert wr_rst with req=4'b1111 -> grant=0, wr_en=0, wr_ptr=0, full=0. After release, first grant=4'b0001.
- Round-robin: req=4'b1111 held, rd_ptr_sync=0 -> grant sequence 0001,0010,0100,1000,0001... for 8 writes. full=1 after the 8th write edge, then grant=0.
- Full release: from full, set rd_ptr_sync=Gray(1)=4'b0001 -> full=0 next cycle. One write occurs; wr_ptr=Gray(9)=4'b1101; full=1 again.
- Wrap: write 16 entries while rd_ptr_sync tracks behind by <= 4 -> wbin wraps 15 -> 0, wr_ptr 4'b1000 -> 4'b0000, full never asserts.
- Sparse: req=4'b1010 only -> grants alternate 0010/1000, wr_data matches the respective slices (e.g. 8'hA1/8'hB3), wr_addr increments 0,1,2...
- ALMOST_FULL_EN, AF_THRESH=6, rd_ptr_sync=0 -> almost_full=0 after 5 writes, 1 after 6, 0 after rd_ptr_sync moves to Gray(2).
